// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and flag-index constants for the execute-stage ALU
package alu_pkg;

    // ARM data-processing opcodes
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Bit positions within a {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 16-op ARM data-processing ALU with NZCV generation
//
// Ports:
//   a, b        in  32  operands (Rn, shifter output)
//   shift_cout  in  1   shifter carry-out, becomes C for logical ops
//   c_in        in  1   registered carry (ADC/SBC/RSC)
//   v_in        in  1   registered overflow, preserved by logical ops
//   op          in  4   opcode
//   result      out 32  ALU result
//   flags       out 4   {N,Z,C,V}
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        shift_cout,
    input  logic        c_in,
    input  logic        v_in,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    // Every arithmetic op is mapped onto one adder: x + y + cin.
    // Subtraction uses the inverted subtrahend with carry-in 1 (or Cq for
    // the with-carry forms), so bit 32 is directly ARM's NOT-borrow carry.
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic        w_arith;
    logic [31:0] w_logic;
    logic [32:0] w_sum;

    always_comb begin
        w_x     = a;
        w_y     = b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_logic = '0;
        case (op)
            OP_AND, OP_TST: w_logic = a & b;
            OP_EOR, OP_TEQ: w_logic = a ^ b;
            OP_SUB, OP_CMP: begin w_x = a; w_y = ~b; w_cin = 1'b1; w_arith = 1'b1; end
            OP_RSB:         begin w_x = b; w_y = ~a; w_cin = 1'b1; w_arith = 1'b1; end
            OP_ADD, OP_CMN: begin w_x = a; w_y = b;  w_cin = 1'b0; w_arith = 1'b1; end
            OP_ADC:         begin w_x = a; w_y = b;  w_cin = c_in; w_arith = 1'b1; end
            OP_SBC:         begin w_x = a; w_y = ~b; w_cin = c_in; w_arith = 1'b1; end
            OP_RSC:         begin w_x = b; w_y = ~a; w_cin = c_in; w_arith = 1'b1; end
            OP_ORR:         w_logic = a | b;
            OP_MOV:         w_logic = b;
            OP_BIC:         w_logic = a & ~b;
            default:        w_logic = ~b;
        endcase
    end

    assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
    assign result = w_arith ? w_sum[31:0] : w_logic;

    // With y already inverted for subtracts, "x and y share a sign and the
    // result sign differs from x" covers both add and subtract overflow.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_C] = w_arith ? w_sum[32] : shift_cout;
        flags[FLAG_V] = w_arith ? ((w_x[31] == w_y[31]) && (result[31] != w_x[31])) : v_in;
    end

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - execute-stage ALU, status-flag register and branch/link handler
//
// Build option: FLAG_BYPASS_EN - when defined, flags_eff forwards live ALU
// flags while s_en is high; otherwise flags_eff is always the registered flags.
//
// Ports:
//   CLK, CLR            clock, synchronous active-high reset
//   a, b, shift_cout    ALU operands and shifter carry
//   alu_op, s_en        opcode, flag-update enable
//   alu_out, alu_flags  combinational result and {N,Z,C,V}
//   flags_q, flags_eff  registered flags, flags seen by the condition tester
//   pc4, offset         branch PC+4 and imm24
//   target_addr         branch target
//   b_instr, bl_instr   decoded B / BL
//   cond_true           condition tester result
//   take_branch         redirect fetch / flush IF/ID
//   link_wr             write PC+4 to R14
module alu_branch_unit
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        shift_cout,
    input  logic [3:0]  alu_op,
    input  logic        s_en,
    output logic [31:0] alu_out,
    output logic [3:0]  alu_flags,
    output logic [3:0]  flags_q,
    output logic [3:0]  flags_eff,
    input  logic [31:0] pc4,
    input  logic [23:0] offset,
    output logic [31:0] target_addr,
    input  logic        b_instr,
    input  logic        bl_instr,
    input  logic        cond_true,
    output logic        take_branch,
    output logic        link_wr
);

    logic [3:0] r_flags;
    logic [31:0] w_ofs_ext;

    alu_core u_alu_core (
        .a          (a),
        .b          (b),
        .shift_cout (shift_cout),
        .c_in       (r_flags[FLAG_C]),
        .v_in       (r_flags[FLAG_V]),
        .op         (alu_op),
        .result     (alu_out),
        .flags      (alu_flags)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_flags <= 4'b0000;
        end else if (s_en) begin
            r_flags <= alu_flags;
        end
    end

    assign flags_q = r_flags;

`ifdef FLAG_BYPASS_EN
    assign flags_eff = s_en ? alu_flags : r_flags;
`else
    assign flags_eff = r_flags;
`endif

    // Word offset: sign-extend imm24 to 30 bits and scale by 4; wraps mod 2^32.
    assign w_ofs_ext   = {{6{offset[23]}}, offset, 2'b00};
    assign target_addr = pc4 + w_ofs_ext;

    // B and BL both asserted behaves as BL, which falls out naturally here.
    assign take_branch = (b_instr | bl_instr) & cond_true;
    assign link_wr     = bl_instr & cond_true;

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - scoreboard bench for alu_branch_unit
module tb_alu_branch_unit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [31:0] a, b;
    logic        shift_cout;
    logic [3:0]  alu_op;
    logic        s_en;
    logic [31:0] alu_out;
    logic [3:0]  alu_flags, flags_q, flags_eff;
    logic [31:0] pc4;
    logic [23:0] offset;
    logic [31:0] target_addr;
    logic        b_instr, bl_instr, cond_true;
    logic        take_branch, link_wr;

    alu_branch_unit dut (
        .CLK(CLK), .CLR(CLR), .a(a), .b(b), .shift_cout(shift_cout),
        .alu_op(alu_op), .s_en(s_en), .alu_out(alu_out), .alu_flags(alu_flags),
        .flags_q(flags_q), .flags_eff(flags_eff), .pc4(pc4), .offset(offset),
        .target_addr(target_addr), .b_instr(b_instr), .bl_instr(bl_instr),
        .cond_true(cond_true), .take_branch(take_branch), .link_wr(link_wr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        bit          is_br;
        logic [31:0] out;
        logic [3:0]  fl;
        logic [3:0]  fq;
        logic [3:0]  fe;
        logic [31:0] tgt;
        logic        tk;
        logic        lk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [3:0] m_fq;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", nm, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, sampled at the falling edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_br) begin
                chk("target_addr", e.id, target_addr, e.tgt);
                chk("take_branch", e.id, {31'd0, take_branch}, {31'd0, e.tk});
                chk("link_wr",     e.id, {31'd0, link_wr},     {31'd0, e.lk});
            end else begin
                chk("alu_out",   e.id, alu_out,            e.out);
                chk("alu_flags", e.id, {28'd0, alu_flags}, {28'd0, e.fl});
                chk("flags_q",   e.id, {28'd0, flags_q},   {28'd0, e.fq});
                chk("flags_eff", e.id, {28'd0, flags_eff}, {28'd0, e.fe});
            end
        end
    end

    // Drive one ALU vector for one cycle; the flag model advances at the edge.
    task automatic alu_vec(input int id, input logic clr, input logic [3:0] op,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic sc, input logic se,
                           input logic [31:0] x_out, input logic [3:0] x_fl);
        exp_t e;
        CLR = clr; alu_op = op; a = va; b = vb; shift_cout = sc; s_en = se;
        e = '{id: id, is_br: 1'b0, out: x_out, fl: x_fl, fq: m_fq,
              fe: (BYPASS && se) ? x_fl : m_fq, tgt: 32'd0, tk: 1'b0, lk: 1'b0};
        exp_q.push_back(e);
        @(posedge CLK);
        if (clr)     m_fq = 4'b0000;
        else if (se) m_fq = x_fl;
        #1;
    endtask

    task automatic br_vec(input int id, input logic [31:0] p, input logic [23:0] o,
                          input logic vb, input logic vbl, input logic c,
                          input logic [31:0] x_tgt, input logic x_tk, input logic x_lk);
        exp_t e;
        s_en = 1'b0; pc4 = p; offset = o; b_instr = vb; bl_instr = vbl; cond_true = c;
        e = '{id: id, is_br: 1'b1, out: 32'd0, fl: 4'd0, fq: 4'd0, fe: 4'd0,
              tgt: x_tgt, tk: x_tk, lk: x_lk};
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int guard;
        CLR = 1'b1; a = '0; b = '0; shift_cout = 1'b0; alu_op = 4'h0; s_en = 1'b1;
        pc4 = '0; offset = '0; b_instr = 1'b0; bl_instr = 1'b0; cond_true = 1'b0;
        @(posedge CLK); #1;
        m_fq = 4'b0000;

        // Reset wins over s_en
        alu_vec( 0, 1, 4'h4, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b1001);
        alu_vec( 1, 1, 4'h4, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b1001);
        // ADD overflow, flags latch next cycle
        alu_vec( 2, 0, 4'h4, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b1001);
        // SUB 5-5 without update, then with update
        alu_vec( 3, 0, 4'h2, 32'd5, 32'd5, 0, 0, 32'h0, 4'b0110);
        alu_vec( 4, 0, 4'h2, 32'd5, 32'd5, 0, 1, 32'h0, 4'b0110);
        // CMP 3 vs 5
        alu_vec( 5, 0, 4'hA, 32'd3, 32'd5, 0, 1, 32'hFFFF_FFFE, 4'b1000);
        // ADD wrap to set C=1
        alu_vec( 6, 0, 4'h4, 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 4'b0110);
        // ADC with Cq=1
        alu_vec( 7, 0, 4'h5, 32'd1, 32'd1, 0, 0, 32'd3, 4'b0000);
        // Set V=1, then AND keeps V and takes C from shifter
        alu_vec( 8, 0, 4'h4, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b1001);
        alu_vec( 9, 0, 4'h0, 32'h0000_F0F0, 32'h0000_0FF0, 1, 1, 32'h0000_00F0, 4'b0011);
        // SBC with Cq=1: 10-3
        alu_vec(10, 0, 4'h6, 32'd10, 32'd3, 0, 0, 32'd7, 4'b0010);
        // RSB 0-1
        alu_vec(11, 0, 4'h3, 32'd1, 32'd0, 0, 0, 32'hFFFF_FFFF, 4'b1000);
        // MVN 0, V preserved from flags_q
        alu_vec(12, 0, 4'hF, 32'd0, 32'd0, 0, 0, 32'hFFFF_FFFF, 4'b1001);
        // BIC
        alu_vec(13, 0, 4'hE, 32'h0000_00FF, 32'h0000_000F, 1, 0, 32'h0000_00F0, 4'b0011);
        // SUB 0-0 with update: bypass visibility
        alu_vec(14, 0, 4'h2, 32'd0, 32'd0, 0, 1, 32'h0, 4'b0110);

        // Branch target and condition handling
        br_vec(20, 32'h100,       24'hFFFFFE, 0, 1, 1, 32'h0000_00F8, 1, 1);
        br_vec(21, 32'h100,       24'h000003, 0, 1, 0, 32'h0000_010C, 0, 0);
        br_vec(22, 32'h100,       24'h000003, 1, 0, 1, 32'h0000_010C, 1, 0);
        br_vec(23, 32'h100,       24'h000003, 1, 1, 1, 32'h0000_010C, 1, 1);
        br_vec(24, 32'h0,         24'h800000, 1, 0, 0, 32'hFE00_0000, 0, 0);
        br_vec(25, 32'hFFFF_FFFC, 24'h000001, 0, 0, 1, 32'h0000_0000, 0, 0);

        // Mid-stream reset discards the pending update
        alu_vec(30, 0, 4'h4, 32'h7FFF_FFFF, 32'h1, 0, 1, 32'h8000_0000, 4'b1001);
        alu_vec(31, 1, 4'h2, 32'd5, 32'd5, 0, 1, 32'h0, 4'b0110);
        alu_vec(32, 0, 4'hD, 32'd0, 32'h1234_5678, 0, 0, 32'h1234_5678, 4'b0000);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
